// File: rtl/enc_pkg.sv
// Shared encoder constants: hypervector width, the elaboration-time shift table
// and the encoder state encoding.
package enc_pkg;

    localparam int HV_DIM  = 16;
    localparam int SHIFT_W = 16;
    localparam int SHIFT_N = 16;

    // One entry per bound channel; a binder instance reads SHIFT_BASE onwards.
    localparam logic [SHIFT_W-1:0] SHIFTS [0:SHIFT_N-1] = '{
        16'd1,  16'd2,  16'd3,  16'd4,  16'd17, 16'd5,  16'd6,  16'd7,
        16'd8,  16'd9,  16'd10, 16'd11, 16'd12, 16'd13, 16'd14, 16'd15
    };

    typedef enum logic [0:0] {
        ENC_IDLE = 1'b0,
        ENC_BIND = 1'b1
    } enc_state_e;

endpackage

// File: rtl/enc_rotate_lane.sv
// Combinational rotator: circular rotate toward MSB, either over the whole
// hypervector (MODE 0) or independently inside each SEG_LEN segment (MODE 1).
module enc_rotate_lane
    import enc_pkg::*;
#(
    parameter int MODE    = 0,
    parameter int SEG_LEN = 64
) (
    input  logic [HV_DIM-1:0]  in_hv,
    input  logic [SHIFT_W-1:0] shift_amt,
    output logic [HV_DIM-1:0]  out_hv
);

    localparam int RLEN = (MODE == 0) ? HV_DIM : SEG_LEN;
    localparam int NSEG = HV_DIM / RLEN;
    localparam logic [SHIFT_W-1:0] RLEN_W = SHIFT_W'(RLEN);

    if (MODE != 0 && MODE != 1) begin : g_bad_mode
        $error("enc_rotate_lane: MODE must be 0 or 1");
    end
    if (MODE == 1 && (SEG_LEN < 1 || HV_DIM % SEG_LEN != 0)) begin : g_bad_seg
        $error("enc_rotate_lane: HV_DIM must be a multiple of SEG_LEN");
    end

    logic [SHIFT_W-1:0] rot;
    assign rot = shift_amt % RLEN_W;

    // With rot == 0 the right shift is by RLEN and contributes nothing.
    for (genvar k = 0; k < NSEG; k++) begin : g_seg
        logic [RLEN-1:0] seg;
        assign seg = in_hv[k*RLEN +: RLEN];
        assign out_hv[k*RLEN +: RLEN] = (seg << rot) | (seg >> (RLEN_W - rot));
    end

endmodule

// File: rtl/enc_binder_array.sv
// Time-multiplexed permutation binder: LANES rotators bind NUM_CH level
// hypervectors over ceil(NUM_CH/LANES) passes into registered outputs.
module enc_binder_array
    import enc_pkg::*;
#(
    parameter int NUM_CH     = 10,
    parameter int LANES      = 10,
    parameter int SHIFT_BASE = 0,
    parameter int MODE       = 0,
    parameter int SEG_LEN    = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_encoding,
    input  logic [HV_DIM-1:0] level_hv   [0:NUM_CH-1],
    output logic [HV_DIM-1:0] shifted_hv [0:NUM_CH-1],
    output logic              busy,
    output logic              done
);

    localparam int PASSES = (NUM_CH + LANES - 1) / LANES;
    localparam int CNT_W  = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam logic [CNT_W-1:0] LAST_PASS = CNT_W'(PASSES - 1);

    localparam logic [0:0] IDLE = ENC_IDLE;
    localparam logic [0:0] BIND = ENC_BIND;

    if (LANES < 1 || LANES > NUM_CH) begin : g_bad_lanes
        $error("enc_binder_array: LANES must be in 1..NUM_CH");
    end
    if (SHIFT_BASE < 0 || SHIFT_BASE + NUM_CH > SHIFT_N) begin : g_bad_base
        $error("enc_binder_array: shift table too short for SHIFT_BASE+NUM_CH");
    end

    logic [0:0]       state;
    logic [CNT_W-1:0] pass_cnt;
    logic [HV_DIM-1:0] lane_out [0:LANES-1];

    // Each lane picks its channel and constant shift by pass; lanes past
    // NUM_CH in a partial last pass see zero and are never written back.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [HV_DIM-1:0]  lane_in;
        logic [SHIFT_W-1:0] lane_shift;

        always_comb begin
            int c;
            lane_in    = '0;
            lane_shift = '0;
            c          = 0;
            for (int p = 0; p < PASSES; p++) begin
                c = p * LANES + l;
                if (c < NUM_CH && int'(pass_cnt) == p) begin
                    lane_in    = level_hv[c];
                    lane_shift = SHIFTS[SHIFT_BASE + c];
                end
            end
        end

        enc_rotate_lane #(
            .MODE    (MODE),
            .SEG_LEN (SEG_LEN)
        ) u_rot (
            .in_hv     (lane_in),
            .shift_amt (lane_shift),
            .out_hv    (lane_out[l])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            pass_cnt <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                shifted_hv[c] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_encoding) begin
                        state    <= BIND;
                        pass_cnt <= '0;
                        busy     <= 1'b1;
                    end
                end
                BIND: begin
                    for (int c = 0; c < NUM_CH; c++) begin
                        if (int'(pass_cnt) == c / LANES) begin
                            shifted_hv[c] <= lane_out[c % LANES];
                        end
                    end
                    if (pass_cnt == LAST_PASS) begin
                        state    <= IDLE;
                        pass_cnt <= '0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                    end else begin
                        pass_cnt <= pass_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
